// File: rtl/seg_mmio_if.sv
// seg_mmio_if: request/response MMIO bus between the bridge and the segment slave
interface seg_mmio_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0] req_be;
  logic resp_valid;
  logic resp_ready;
  logic resp_err;
  modport master(output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                 input req_ready, resp_valid, resp_err);
  modport slave(input req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                output req_ready, resp_valid, resp_err);
endinterface

// File: rtl/seg_mmio_slave.sv
// seg_mmio_slave: write-only MMIO slave driving six blinkable seven-segment digits
module seg_mmio_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int BLINK_DIV = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  seg_mmio_if.slave bus,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);
  localparam int CW = BLINK_DIV > 2 ? $clog2(BLINK_DIV) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
  logic [0:0] st;
  logic err_q;
  logic [CW-1:0] cnt;
  logic phase, phase_n, wrap, acc, hit, err, wr;
  logic [2:0] idx;
  logic [5:0] dig [6];
  logic [5:0] dig_n [6];
  logic [6:0] hex_q [6];
  logic unused_bits;
  // Decoded glyph in {g,f,e,d,c,b,a} order; blank wins over the value, blink blanks on phase 1
  function automatic logic [6:0] seg(input logic [5:0] d, input logic ph);
    logic [6:0] s;
    case (d[3:0])
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    s = (d[4] || (d[5] && ph)) ? 7'h7F : s;
    return ACTIVE_LOW ? s : ~s;
  endfunction
  assign unused_bits = ^{bus.req_wdata[31:6], bus.req_be[3:1]};
  assign bus.req_ready = st == IDLE;
  assign bus.resp_valid = st == RESP;
  assign bus.resp_err = err_q;
  assign idx = bus.req_addr[4:2];
  assign hit = ((bus.req_addr & ~32'h1C) == BASE_ADDR) && idx <= 3'd5;
  assign err = !bus.req_we || !hit || |bus.req_addr[1:0];
  assign acc = bus.req_valid && st == IDLE;
  assign wr = acc && !err && bus.req_be[0];
  assign wrap = cnt == CW'(BLINK_DIV - 1);
  assign phase_n = phase ^ wrap;
  assign {hex5, hex4, hex3, hex2, hex1, hex0} = {hex_q[5], hex_q[4], hex_q[3], hex_q[2], hex_q[1], hex_q[0]};
  // Next digit state: the addressed digit takes the store data on an accepted hit
  always_comb begin
    for (int i = 0; i < 6; i++) dig_n[i] = (wr && idx == 3'(i)) ? bus.req_wdata[5:0] : dig[i];
  end
  // Handshake FSM with latched error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      err_q <= 1'b0;
    end else if (acc) begin
      st <= RESP;
      err_q <= err;
    end else if (st == RESP && bus.resp_ready) begin
      st <= IDLE;
      err_q <= 1'b0;
    end
  end
  // Free-running blink timer, independent of bus traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      phase <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      phase <= phase_n;
    end
  end
  // Digit registers and segment pins; pins use next-state so a store shows with its response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        dig[i] <= 6'h10;
        hex_q[i] <= BLANK;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        dig[i] <= dig_n[i];
        hex_q[i] <= seg(dig_n[i], phase_n);
      end
    end
  end
endmodule
